game_tick_scheduler: RTL and testbench

// - Owns the game's timebase: divides clk into a base frame tick, then hands per-requester tick enables
//   to NUM_REQ movers (pacman, ghosts, ...) at individually programmable rates, plus a one-second tick.
// - Sequences run/pause/stop for all movers from one place.
// - Sits between the top-level control FSM and the mover/animation blocks.

---
 rtl/game_tick_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Game timebase: base frame tick, per-requester divided tick enables, one-second tick, run/pause/stop FSM.
// Optional frame counter enabled by defining GAME_TICK_FRAME_CNT_EN.
module game_tick_scheduler #(
    parameter int TICK_MAX      = 1249999,
    parameter int TICKS_PER_SEC = 60,
    parameter int NUM_REQ       = 4,
    parameter int DIV_W         = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       stop,
    input  logic                       cfg_load,
    input  logic [NUM_REQ*DIV_W-1:0]   div_cfg,
    output logic                       base_tick,
    output logic [NUM_REQ-1:0]         tick_en,
    output logic                       sec_tick,
    output logic [1:0]                 state,
    output logic [15:0]                frame_cnt
);

    localparam int BASE_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    state_t                     state_q, state_d;
    logic [BASE_W-1:0]          base_cnt_q, base_cnt_d;
    logic [SEC_W-1:0]           sec_cnt_q, sec_cnt_d;
    logic [NUM_REQ*DIV_W-1:0]   div_shd_q, div_shd_d;
    logic [NUM_REQ*DIV_W-1:0]   div_act_q, div_act_d;
    logic                       cfg_pend_q, cfg_pend_d;
    logic                       base_tick_q, base_tick_d;
    logic                       sec_tick_q, sec_tick_d;
    logic [NUM_REQ-1:0]         tick_en_q, tick_en_d;

    logic run_active;
    logic wrap;
    logic clear_cnt;
    logic cfg_apply;

    // stop > pause > start; pause outside RUN still blocks a start that cycle
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
        end
    end

    // a pause or stop arriving on the wrap cycle freezes everything for that cycle
    assign run_active = (state_q == ST_RUN) && !stop && !pause;
    assign wrap       = run_active && (base_cnt_q == BASE_W'(TICK_MAX));
    assign clear_cnt  = stop || (state_q == ST_IDLE);
    assign cfg_apply  = cfg_pend_q && ((state_q != ST_RUN) || wrap);

    always_comb begin
        base_cnt_d  = base_cnt_q;
        sec_cnt_d   = sec_cnt_q;
        base_tick_d = 1'b0;
        sec_tick_d  = 1'b0;
        if (clear_cnt) begin
            base_cnt_d = '0;
            sec_cnt_d  = '0;
        end else if (wrap) begin
            base_cnt_d  = '0;
            base_tick_d = 1'b1;
            if (sec_cnt_q == SEC_W'(TICKS_PER_SEC - 1)) begin
                sec_cnt_d  = '0;
                sec_tick_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
        end else if (run_active) begin
            base_cnt_d = base_cnt_q + BASE_W'(1);
        end
    end

    // the wrap that applies a pending config is still governed by the old divides
    always_comb begin
        div_shd_d  = cfg_load ? div_cfg : div_shd_q;
        div_act_d  = cfg_apply ? div_shd_q : div_act_q;
        cfg_pend_d = cfg_load | (cfg_pend_q & ~cfg_apply);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [DIV_W-1:0] div_i;
            logic [DIV_W-1:0] sub_q, sub_d;
            logic             tick_i;

            assign div_i = div_act_q[gi*DIV_W +: DIV_W];

            always_comb begin
                sub_d  = sub_q;
                tick_i = 1'b0;
                if (wrap && (div_i != '0)) begin
                    if (sub_q == (div_i - DIV_W'(1))) begin
                        sub_d  = '0;
                        tick_i = 1'b1;
                    end else begin
                        sub_d = sub_q + DIV_W'(1);
                    end
                end
                if (clear_cnt || cfg_apply) begin
                    sub_d = '0;
                end
            end

            assign tick_en_d[gi] = tick_i;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sub_q <= '0;
                end else begin
                    sub_q <= sub_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_cnt_q  <= '0;
            sec_cnt_q   <= '0;
            div_shd_q   <= '0;
            div_act_q   <= '0;
            cfg_pend_q  <= 1'b0;
            base_tick_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            tick_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_cnt_q  <= base_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            div_shd_q   <= div_shd_d;
            div_act_q   <= div_act_d;
            cfg_pend_q  <= cfg_pend_d;
            base_tick_q <= base_tick_d;
            sec_tick_q  <= sec_tick_d;
            tick_en_q   <= tick_en_d;
        end
    end

`ifdef GAME_TICK_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (clear_cnt) begin
            frame_cnt_d = '0;
        end else if (wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'h0000;
`endif

    assign base_tick = base_tick_q;
    assign sec_tick  = sec_tick_q;
    assign tick_en   = tick_en_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed plus randomized bench for game_tick_scheduler against an arithmetic reference model.
// Follows GAME_TICK_FRAME_CNT_EN to decide the expected frame_cnt behaviour.
module tb_game_tick_scheduler;

    localparam int TM  = 3;
    localparam int TPS = 5;
    localparam int NR  = 4;
    localparam int DW  = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, cfg_load = 1'b0;
    logic [15:0] div_cfg = 16'h0;
    logic        base_tick;
    logic [3:0]  tick_en;
    logic        sec_tick;
    logic [1:0]  state;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    // Reference model: counts of active run cycles and base ticks, not counter registers
    int          m_state;
    int          m_run_cyc;
    int          m_nb;
    int          m_nb_cfg;
    logic [15:0] m_shadow, m_act;
    bit          m_pend;
    bit          e_base, e_sec;
    logic [3:0]  e_tick;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .TICK_MAX(TM), .TICKS_PER_SEC(TPS), .NUM_REQ(NR), .DIV_W(DW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .stop(stop),
        .cfg_load(cfg_load), .div_cfg(div_cfg), .base_tick(base_tick), .tick_en(tick_en),
        .sec_tick(sec_tick), .state(state), .frame_cnt(frame_cnt)
    );

    task automatic model_reset();
        m_state = S_IDLE; m_run_cyc = 0; m_nb = 0; m_nb_cfg = 0;
        m_shadow = '0; m_act = '0; m_pend = 0;
        e_base = 0; e_sec = 0; e_tick = '0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit t, input bit c, input logic [15:0] d);
        bit wrap = 0;
        bit apply;
        int dv;
        e_base = 0; e_sec = 0; e_tick = '0;
        if (m_state == S_RUN && !t && !p) begin
            m_run_cyc++;
            if (m_run_cyc % (TM + 1) == 0) wrap = 1;
        end
        apply = m_pend && (m_state != S_RUN || wrap);
        if (wrap) begin
            m_nb++; m_nb_cfg++;
            e_base = 1;
            e_sec  = (m_nb % TPS) == 0;
            for (int i = 0; i < NR; i++) begin
                dv = int'(m_act[i*DW +: DW]);
                e_tick[i] = (dv != 0) && ((m_nb_cfg % dv) == 0);
            end
        end
        if (apply) begin m_act = m_shadow; m_nb_cfg = 0; end
        if (c) begin m_shadow = d; m_pend = 1; end
        else if (apply) m_pend = 0;
        if (t || m_state == S_IDLE) begin m_run_cyc = 0; m_nb = 0; m_nb_cfg = 0; end
        if (t) m_state = S_IDLE;
        else if (p) begin if (m_state == S_RUN) m_state = S_PAUSED; end
        else if (s && m_state != S_RUN) m_state = S_RUN;
    endtask

    function automatic logic [15:0] exp_frame();
`ifdef GAME_TICK_FRAME_CNT_EN
        return 16'(m_nb % 65536);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), 32'(m_state));
        chk("base_tick", 32'(base_tick), 32'(e_base));
        chk("tick_en", 32'(tick_en), 32'(e_tick));
        chk("sec_tick", 32'(sec_tick), 32'(e_sec));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frame()));
    endtask

    task automatic step(input bit s, input bit p, input bit t, input bit c, input logic [15:0] d);
        start = s; pause = p; stop = t; cfg_load = c; div_cfg = d;
        @(posedge clk);
        model_edge(s, p, t, c, d);
        #1;
        start = 0; pause = 0; stop = 0; cfg_load = 0;
        step_no++;
        $display("step %0d in(st=%0b pa=%0b sp=%0b cl=%0b div=%h) out(state=%0d base=%0b tick=%b sec=%0b frame=%0d)",
                 step_no, s, p, t, c, d, state, base_tick, tick_en, sec_tick, frame_cnt);
        check_outputs();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 16'h0);
    endtask

    // cycles until the next base_tick, or -1 when the bound expires
    task automatic wait_base(input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            idle_step();
            if (base_tick === 1'b1) begin n = c; break; end
        end
    endtask

    initial begin
        int n;
        int first_sec;
        int nbt;

        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_outs", 32'({base_tick, tick_en, sec_tick, frame_cnt}), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_step();

        // divides {0,3,2,1}, then run long enough for the first second
        step(0, 0, 0, 1, 16'h0321);
        idle_step();
        step(1, 0, 0, 0, 16'h0);
        first_sec = -1;
        for (int c = 1; c <= 25; c++) begin
            idle_step();
            if (sec_tick === 1'b1 && first_sec < 0) first_sec = c;
        end
        chk("first_sec_cycle", 32'(first_sec), 32'd20);

        // pause at base count 1 after two base ticks, resume
        step(0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        wait_base(10, n);
        chk("base1_latency", 32'(n), 32'd4);
        wait_base(10, n);
        chk("base2_latency", 32'(n), 32'd4);
        idle_step();
        step(0, 1, 0, 0, 16'h0);
        chk("paused_state", 32'(state), 32'(S_PAUSED));
        repeat (10) idle_step();
        step(1, 0, 0, 0, 16'h0);
        wait_base(10, n);
        chk("resume_latency", 32'(n), 32'd3);
        repeat (12) idle_step();

        // retarget requester 0 from 1 to 4 mid-period
        idle_step();
        step(0, 0, 0, 1, 16'h0324);
        repeat (40) idle_step();

        // stop and start together, then start
        step(1, 0, 1, 0, 16'h0);
        chk("stop_start_state", 32'(state), 32'(S_IDLE));
        step(1, 0, 0, 0, 16'h0);
        wait_base(10, n);
        chk("restart_latency", 32'(n), 32'd4);

        // frame counter after seven base ticks, then stop
        step(0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        nbt = 0;
        for (int c = 0; c < 60 && nbt < 7; c++) begin
            idle_step();
            if (base_tick === 1'b1) nbt++;
        end
`ifdef GAME_TICK_FRAME_CNT_EN
        chk("frame_after_7", 32'(frame_cnt), 32'd7);
`else
        chk("frame_after_7", 32'(frame_cnt), 32'd0);
`endif
        step(0, 0, 1, 0, 16'h0);
        chk("frame_after_stop", 32'(frame_cnt), 32'd0);

        // asynchronous reset in the middle of RUN
        step(1, 0, 0, 0, 16'h0);
        repeat (6) idle_step();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'(S_IDLE));
        chk("async_rst_outs", 32'({base_tick, tick_en, sec_tick, frame_cnt}), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        repeat (8) idle_step();

        // randomized control and configuration traffic
        step(0, 0, 0, 1, 16'h4321);
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0,
                 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
